// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
`timescale 1ns/1ps
package uart_pkg;

   localparam int CLK_HZ        = 50_000_000;
   localparam int BAUD          = 9600;
   localparam int BIT_CYCLES    = CLK_HZ / BAUD;
   localparam int BUSY_WAIT_MAX = 15;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority selector: first set request strictly above ptr, wrapping to 0.
`timescale 1ns/1ps
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         winner,
   output logic                 any_valid
);

   logic found;

   // Two passes: indices above ptr first, then the wrapped range 0..ptr.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[k] && (k > int'(ptr))) begin
            winner[k] = 1'b1;
            found     = 1'b1;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (!found && req[k] && (k <= int'(ptr))) begin
            winner[k] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_txd among N_REQ byte-stream requesters, one whole packet per grant.
//
//   state     | meaning
//   IDLE      | no owner, arbitrate among req_valid
//   LOAD      | owner granted, waiting for its next byte (timeout runs here)
//   WAIT_BUSY | start pulse issued, waiting for txd_busy to rise
//   WAIT_DONE | frame shifting out, waiting for txd_busy to fall
//   GAP       | idle spacing after a packet before re-arbitration
`timescale 1ns/1ps
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 0,
   parameter int TIMEOUT    = 1000000
) (
   input  logic               clk50M,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               txd_en,
   output logic [7:0]         txd_data,
   input  logic               txd_busy,
   output logic               arb_busy
);

   localparam int PW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);

   arb_state_t      state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner_idx;
   logic            last_q;
   logic [TW-1:0]   tmo_cnt;
   logic [3:0]      busy_cnt;
   logic [GW-1:0]   gap_cnt;

   logic [N_REQ-1:0] winner;
   logic             any_req;
   logic [PW-1:0]    win_idx;
   logic             own_valid;
   logic             own_last;
   logic [7:0]       own_data;
   logic             byte_done;

   rr_pick #(.N(N_REQ)) u_pick (
      .req       (req_valid),
      .ptr       (ptr),
      .winner    (winner),
      .any_valid (any_req)
   );

   always_comb begin
      win_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (winner[k]) win_idx = PW'(k);
      end
   end

   assign own_valid = req_valid[owner_idx];
   assign own_last  = req_last[owner_idx];
   assign own_data  = req_data[{owner_idx, 3'b000} +: 8];

   // A missing busy rise after BUSY_WAIT_MAX cycles is treated as a sent byte.
   assign byte_done = !txd_busy &&
                      ((state == WAIT_DONE) ||
                       ((state == WAIT_BUSY) && (busy_cnt == 4'(BUSY_WAIT_MAX - 1))));

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         req_ready <= '0;
         txd_en    <= 1'b0;
         txd_data  <= '0;
         arb_busy  <= 1'b0;
         ptr       <= PW'(N_REQ - 1);
         owner_idx <= '0;
         last_q    <= 1'b0;
         tmo_cnt   <= '0;
         busy_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         txd_en    <= 1'b0;
         req_ready <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant     <= winner;
                  owner_idx <= win_idx;
                  arb_busy  <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (own_valid) begin
                  txd_en    <= 1'b1;
                  req_ready <= grant;
                  txd_data  <= own_data;
                  last_q    <= own_last;
                  tmo_cnt   <= '0;
                  busy_cnt  <= '0;
                  state     <= WAIT_BUSY;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  grant    <= '0;
                  ptr      <= owner_idx;
                  tmo_cnt  <= '0;
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_BUSY, WAIT_DONE: begin
               if (byte_done) begin
                  if (!last_q) begin
                     state <= LOAD;
                  end else begin
                     grant   <= '0;
                     ptr     <= owner_idx;
                     gap_cnt <= '0;
                     if (GAP_CYCLES > 0) begin
                        state <= GAP;
                     end else begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                     end
                  end
               end else if (state == WAIT_BUSY) begin
                  busy_cnt <= busy_cnt + 1'b1;
                  if (txd_busy) state <= WAIT_DONE;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               arb_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a byte-source model per requester and a uart_txd model.
`timescale 1ns/1ps
module tb_uart_tx_arb;

   localparam int N     = 4;
   localparam int GAP   = 50;
   localparam int TMO   = 100;
   localparam int FRAME = 30;   // shortened frame so the run stays small

   logic           clk50M = 1'b0;
   logic           rst_n  = 1'b0;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic           txd_en, txd_busy, arb_busy;
   logic [7:0]     txd_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] src_byte [N][16];
   logic       src_last [N][16];
   int         wr_cnt [N];
   int         rd_cnt [N];

   logic [7:0] log_byte  [64];
   logic [3:0] log_grant [64];
   int         n_log = 0;
   int         fcnt  = 0;

   logic lock_mon  = 1'b0;
   int   lock_base = 0;
   logic lock_viol = 1'b0;

   uart_tx_arb #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
      .clk50M    (clk50M),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .txd_en    (txd_en),
      .txd_data  (txd_data),
      .txd_busy  (txd_busy),
      .arb_busy  (arb_busy)
   );

   always #10 clk50M = ~clk50M;

   always_comb begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]      = rd_cnt[i] < wr_cnt[i];
         req_last[i]       = src_last[i][rd_cnt[i][3:0]];
         req_data[8*i +: 8] = src_byte[i][rd_cnt[i][3:0]];
      end
   end

   // Sources advance on req_ready; a reset drops whatever was pending.
   always @(posedge clk50M or negedge rst_n) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n) rd_cnt[i] <= wr_cnt[i];
         else if (req_ready[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      end
   end

   always @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         txd_busy <= 1'b0;
         fcnt     <= 0;
      end else if (txd_en) begin
         txd_busy               <= 1'b1;
         fcnt                   <= FRAME;
         log_byte[n_log[5:0]]   <= txd_data;
         log_grant[n_log[5:0]]  <= grant;
         n_log                  <= n_log + 1;
      end else if (txd_busy) begin
         if (fcnt == 1) txd_busy <= 1'b0;
         fcnt <= fcnt - 1;
      end
   end

   always @(negedge clk50M) begin
      if (lock_mon && grant == 4'b0100 &&
          ((n_log < lock_base + 3) || (n_log == lock_base + 3 && txd_busy)))
         lock_viol <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] b, input logic l);
      src_byte[r][wr_cnt[r][3:0]] = b;
      src_last[r][wr_cnt[r][3:0]] = l;
      wr_cnt[r] = wr_cnt[r] + 1;
   endtask

   task automatic wait_log(input int target, input int limit, input string tag);
      for (int k = 0; k < limit && n_log < target; k++) @(negedge clk50M);
      chk(tag, 32'(n_log >= target), 1);
   endtask

   task automatic wait_busy(input logic lvl, input int limit, input string tag);
      for (int k = 0; k < limit && txd_busy !== lvl; k++) @(negedge clk50M);
      chk(tag, 32'(txd_busy), 32'(lvl));
   endtask

   task automatic wait_idle(input int limit, input string tag);
      for (int k = 0; k < limit && (arb_busy !== 1'b0 || txd_busy !== 1'b0); k++)
         @(negedge clk50M);
      chk(tag, 32'(arb_busy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk50M);
      rst_n = 1'b0;
      repeat (2) @(negedge clk50M);
      rst_n = 1'b1;
      @(negedge clk50M);
   endtask

   initial begin
      int   base, n, c3;
      logic drop, idle_low;

      for (int i = 0; i < N; i++) wr_cnt[i] = 0;
      repeat (3) @(negedge clk50M);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_txd_en", 32'(txd_en), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_txd_data", 32'(txd_data), 0);
      chk("rst_arb_busy", 32'(arb_busy), 0);
      rst_n = 1'b1;
      @(negedge clk50M);

      // single byte from requester 0
      push(0, 8'h55, 1'b1);
      @(negedge clk50M);
      chk("single_grant", 32'(grant), 32'h1);
      @(negedge clk50M);
      chk("single_txd_en", 32'(txd_en), 1);
      chk("single_txd_data", 32'(txd_data), 32'h55);
      chk("single_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk50M);
      chk("single_en_pulse", 32'(txd_en), 0);
      chk("single_ready_pulse", 32'(req_ready), 0);
      wait_busy(1'b0, 200, "single_busy_fall");
      chk("single_grant_held", 32'(grant), 32'h1);
      @(negedge clk50M);
      chk("single_grant_release", 32'(grant), 0);
      chk("single_en_count", 32'(n_log), 1);
      wait_idle(300, "single_idle");

      // round robin, all four valid twice
      do_reset();
      base = n_log;
      for (int rep = 0; rep < 2; rep++)
         for (int r = 0; r < N; r++) push(r, 8'h10 + 8'(r), 1'b1);
      wait_log(base + 8, 3000, "rr_wait");
      for (int k = 0; k < 8; k++)
         chk("rr_order", 32'(log_byte[base + k]), 32'h10 + 32'(k % 4));
      wait_idle(300, "rr_idle");

      // packet lock: req1 three bytes while req2 waits
      lock_base = n_log;
      lock_mon  = 1'b1;
      push(1, 8'hA1, 1'b0);
      push(1, 8'hA2, 1'b0);
      push(1, 8'hA3, 1'b1);
      push(2, 8'hB0, 1'b1);
      wait_log(lock_base + 4, 2000, "lock_wait");
      lock_mon = 1'b0;
      chk("lock_b0", 32'(log_byte[lock_base]), 32'hA1);
      chk("lock_b1", 32'(log_byte[lock_base + 1]), 32'hA2);
      chk("lock_b2", 32'(log_byte[lock_base + 2]), 32'hA3);
      chk("lock_b3", 32'(log_byte[lock_base + 3]), 32'hB0);
      chk("lock_grant_b3", 32'(log_grant[lock_base + 3]), 32'h4);
      chk("lock_no_early_grant", 32'(lock_viol), 0);
      wait_idle(300, "lock_idle");

      // timeout: pointer is 2, so req3 beats req0, then stalls mid-packet
      base = n_log;
      push(3, 8'hC0, 1'b0);
      push(0, 8'h0D, 1'b1);
      wait_log(base + 1, 200, "tmo_first");
      chk("tmo_byte", 32'(log_byte[base]), 32'hC0);
      chk("tmo_owner", 32'(log_grant[base]), 32'h8);
      wait_busy(1'b1, 50, "tmo_busy_rise");
      wait_busy(1'b0, 200, "tmo_busy_fall");
      n = 0;
      while (n < 300 && grant === 4'b1000) begin
         @(negedge clk50M);
         n++;
      end
      // busy fall + 1 cycle to re-enter LOAD + 100 timeout cycles
      chk("tmo_revoke_cycles", 32'(n), 101);
      chk("tmo_grant_revoked", 32'(grant), 0);
      wait_log(base + 2, 300, "tmo_next");
      chk("tmo_req0_byte", 32'(log_byte[base + 1]), 32'h0D);
      chk("tmo_req0_owner", 32'(log_grant[base + 1]), 32'h1);
      c3 = 0;
      for (int k = base; k < n_log; k++) if (log_grant[k] == 4'b1000) c3++;
      chk("tmo_req3_en_count", 32'(c3), 1);
      wait_idle(300, "tmo_idle");

      // asynchronous reset during WAIT_DONE of a 2-byte packet
      base = n_log;
      push(1, 8'h21, 1'b0);
      push(1, 8'h22, 1'b1);
      wait_log(base + 1, 200, "rstm_first");
      wait_busy(1'b1, 50, "rstm_busy");
      repeat (3) @(negedge clk50M);
      chk("rstm_pre_grant", 32'(grant), 32'h2);
      #3 rst_n = 1'b0;
      #1;
      chk("rstm_grant", 32'(grant), 0);
      chk("rstm_txd_en", 32'(txd_en), 0);
      chk("rstm_req_ready", 32'(req_ready), 0);
      chk("rstm_arb_busy", 32'(arb_busy), 0);
      repeat (3) @(negedge clk50M);
      rst_n = 1'b1;
      @(negedge clk50M);
      chk("rstm_no_more_en", 32'(n_log), 32'(base + 1));
      base = n_log;
      for (int r = 0; r < N; r++) push(r, 8'h30 + 8'(r), 1'b1);
      wait_log(base + 4, 1500, "rstm_after");
      chk("rstm_first_winner", 32'(log_grant[base]), 32'h1);
      for (int k = 0; k < 4; k++)
         chk("rstm_order", 32'(log_byte[base + k]), 32'h30 + 32'(k));
      wait_idle(300, "rstm_idle");

      // inter-packet gap, two single-byte packets from req2
      base = n_log;
      push(2, 8'h61, 1'b1);
      push(2, 8'h62, 1'b1);
      wait_log(base + 1, 200, "gap_first");
      wait_busy(1'b1, 50, "gap_busy_rise");
      wait_busy(1'b0, 200, "gap_busy_fall");
      n        = 0;
      drop     = 1'b0;
      idle_low = 1'b1;
      while (n < 200 && txd_en !== 1'b1) begin
         @(negedge clk50M);
         n++;
         if (n <= 50 && arb_busy !== 1'b1) drop = 1'b1;
         if (n == 51) idle_low = arb_busy;
      end
      // 1 cycle to leave WAIT_DONE, 50 GAP, 1 IDLE, 1 LOAD
      chk("gap_en_delay", 32'(n), 53);
      chk("gap_busy_held", 32'(drop), 0);
      chk("gap_idle_low", 32'(idle_low), 0);
      wait_log(base + 2, 50, "gap_second");
      chk("gap_second_byte", 32'(log_byte[base + 1]), 32'h62);
      wait_idle(300, "gap_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
